// File: rtl/bricks_pkg.sv
// Shared Bricks game definitions: screen geometry, fixed-point format and
// the bonus object state encoding.
package bricks_pkg;

  localparam int unsigned COORD_W       = 11;
  localparam int unsigned FRAC_BITS     = 6;
  localparam int unsigned FP_W          = COORD_W + FRAC_BITS;
  localparam int unsigned SCREEN_WIDTH  = 640;
  localparam int unsigned SCREEN_BOTTOM = 479;

  typedef enum logic {
    IDLE    = 1'b0,
    FALLING = 1'b1
  } bonus_state_t;

endpackage

// File: rtl/bonus_move.sv
// Falling bonus object: spawned at a broken brick, falls once per frame with
// fixed-point acceleration until caught by the paddle or it leaves the screen.
module bonus_move
  import bricks_pkg::*;
#(
  parameter int unsigned FIXED_POINT_MULTIPLIER = 64,
  parameter int unsigned INITIAL_SPEED_Y        = 64,
  parameter int unsigned ACCEL_Y                = 8,
  parameter int unsigned MAX_SPEED_Y            = 256,
  parameter int unsigned OBJECT_HEIGHT          = 16
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               spawn,
  input  logic [COORD_W-1:0] spawnX,
  input  logic [COORD_W-1:0] spawnY,
  input  logic               collisionPaddle,
  input  logic               pause,
  output logic [COORD_W-1:0] topLeftMoveX,
  output logic [COORD_W-1:0] topLeftMoveY,
  output logic               preStart,
  output logic               bonusActive,
  output logic               caught,
  output logic               missed
);

  localparam int unsigned SUM_W      = FP_W + 1;
  localparam int unsigned MISS_LIMIT = SCREEN_BOTTOM - OBJECT_HEIGHT;

  bonus_state_t        state_q, state_d;
  logic [COORD_W-1:0]  x_q, x_d;
  logic [FP_W-1:0]     y_q, y_d;
  logic [FP_W-1:0]     speed_q, speed_d;
  logic                caught_q, caught_d;
  logic                missed_q, missed_d;
  logic                pre_start_q, pre_start_d;
  logic                bonus_active_q, bonus_active_d;

  logic [SUM_W-1:0]    new_y;
  logic [FP_W-1:0]     speed_inc;

  // Next-state and datapath; collision outranks the per-frame move
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    speed_d   = speed_q;
    caught_d  = 1'b0;
    missed_d  = 1'b0;
    new_y     = SUM_W'(y_q) + SUM_W'(speed_q);
    speed_inc = speed_q + FP_W'(ACCEL_Y);

    unique case (state_q)
      IDLE: begin
        if (spawn) begin
          x_d     = spawnX;
          y_d     = FP_W'(spawnY) << FRAC_BITS;
          speed_d = FP_W'(INITIAL_SPEED_Y);
          state_d = FALLING;
        end
      end
      FALLING: begin
        if (collisionPaddle) begin
          caught_d = 1'b1;
          state_d  = IDLE;
        end else if (startOfFrame && !pause) begin
          y_d = new_y[FP_W-1:0];
          if ((new_y >> FRAC_BITS) > SUM_W'(MISS_LIMIT)) begin
            missed_d = 1'b1;
            state_d  = IDLE;
          end else if (speed_inc > FP_W'(MAX_SPEED_Y)) begin
            speed_d = FP_W'(MAX_SPEED_Y);
          end else begin
            speed_d = speed_inc;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    pre_start_d    = (state_d == IDLE);
    bonus_active_d = (state_d == FALLING);
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q        <= IDLE;
      x_q            <= '0;
      y_q            <= '0;
      speed_q        <= FP_W'(INITIAL_SPEED_Y);
      caught_q       <= 1'b0;
      missed_q       <= 1'b0;
      pre_start_q    <= 1'b1;
      bonus_active_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      x_q            <= x_d;
      y_q            <= y_d;
      speed_q        <= speed_d;
      caught_q       <= caught_d;
      missed_q       <= missed_d;
      pre_start_q    <= pre_start_d;
      bonus_active_q <= bonus_active_d;
    end
  end

  assign topLeftMoveX = x_q;
  assign topLeftMoveY = y_q[FP_W-1:FRAC_BITS];
  assign preStart     = pre_start_q;
  assign bonusActive  = bonus_active_q;
  assign caught       = caught_q;
  assign missed       = missed_q;

endmodule

// File: tb/tb_bonus_move.sv
// Directed bench for bonus_move: a per-cycle vector table plus hand-written
// long-fall sequences covering acceleration, saturation, pause and exit.
module tb_bonus_move;

  logic        clk = 1'b0;
  logic        resetN;
  logic        startOfFrame;
  logic        spawn;
  logic [10:0] spawnX;
  logic [10:0] spawnY;
  logic        collisionPaddle;
  logic        pause;
  logic [10:0] topLeftMoveX;
  logic [10:0] topLeftMoveY;
  logic        preStart;
  logic        bonusActive;
  logic        caught;
  logic        missed;

  int checks = 0;
  int errors = 0;

  bonus_move dut (
    .clk            (clk),
    .resetN         (resetN),
    .startOfFrame   (startOfFrame),
    .spawn          (spawn),
    .spawnX         (spawnX),
    .spawnY         (spawnY),
    .collisionPaddle(collisionPaddle),
    .pause          (pause),
    .topLeftMoveX   (topLeftMoveX),
    .topLeftMoveY   (topLeftMoveY),
    .preStart       (preStart),
    .bonusActive    (bonusActive),
    .caught         (caught),
    .missed         (missed)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        spawn;
    logic [10:0] sx;
    logic [10:0] sy;
    logic        sof;
    logic        coll;
    logic        pause;
    logic [10:0] ex;
    logic [10:0] ey;
    logic        epre;
    logic        eact;
    logic        ecaught;
    logic        emissed;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic sp, int sx, int sy, logic sof,
                              logic coll, logic p, int ex, int ey, logic epre,
                              logic eact, logic ec, logic em);
    vec_t v;
    v.rst_n = r; v.spawn = sp; v.sx = 11'(sx); v.sy = 11'(sy);
    v.sof = sof; v.coll = coll; v.pause = p;
    v.ex = 11'(ex); v.ey = 11'(ey); v.epre = epre; v.eact = eact;
    v.ecaught = ec; v.emissed = em;
    return v;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(string tag, int ex, int ey, logic epre, logic eact,
                         logic ec, logic em);
    chk({tag, ".x"}, int'(topLeftMoveX), ex);
    chk({tag, ".y"}, int'(topLeftMoveY), ey);
    chk({tag, ".preStart"}, int'(preStart), int'(epre));
    chk({tag, ".bonusActive"}, int'(bonusActive), int'(eact));
    chk({tag, ".caught"}, int'(caught), int'(ec));
    chk({tag, ".missed"}, int'(missed), int'(em));
  endtask

  // Inputs change on the falling edge; outputs are sampled one full cycle later
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    resetN = 1'b1; spawn = 1'b0; startOfFrame = 1'b0;
    collisionPaddle = 1'b0; pause = 1'b0;
  endtask

  task automatic frames(int n, logic p);
    for (int i = 0; i < n; i++) begin
      startOfFrame = 1'b1; pause = p;
      tick();
      startOfFrame = 1'b0; pause = 1'b0;
    end
  endtask

  initial begin
    resetN = 1'b0; spawn = 1'b0; spawnX = '0; spawnY = '0;
    startOfFrame = 1'b0; collisionPaddle = 1'b0; pause = 1'b0;

    //          rst sp  sx  sy  sof col p   ex  ey  pre act c  m
    vecs.push_back(mk(0, 0,   0,   0, 0, 0, 0,   0,   0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0,   0,   0, 0, 0, 0,   0,   0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0,   0,   0, 1, 1, 0,   0,   0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 200, 100, 0, 1, 0, 200, 100, 0, 1, 0, 0));
    vecs.push_back(mk(1, 0,   0,   0, 0, 0, 0, 200, 100, 0, 1, 0, 0));
    vecs.push_back(mk(1, 0,   0,   0, 1, 0, 0, 200, 101, 0, 1, 0, 0));
    vecs.push_back(mk(1, 0,   0,   0, 1, 0, 0, 200, 102, 0, 1, 0, 0));
    vecs.push_back(mk(1, 0,   0,   0, 1, 0, 1, 200, 102, 0, 1, 0, 0));
    vecs.push_back(mk(1, 1,  50,  50, 0, 0, 0, 200, 102, 0, 1, 0, 0));
    vecs.push_back(mk(1, 0,   0,   0, 1, 0, 0, 200, 103, 0, 1, 0, 0));
    vecs.push_back(mk(1, 0,   0,   0, 1, 1, 1, 200, 103, 1, 0, 1, 0));
    vecs.push_back(mk(1, 0,   0,   0, 1, 0, 0, 200, 103, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1,  10, 250, 0, 0, 0,  10, 250, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0,   0,   0, 1, 1, 0,   0,   0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0,   0,   0, 0, 0, 0,   0,   0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1,   7, 462, 0, 0, 0,   7, 462, 0, 1, 0, 0));
    vecs.push_back(mk(1, 0,   0,   0, 1, 0, 0,   7, 463, 0, 1, 0, 0));
    vecs.push_back(mk(1, 0,   0,   0, 1, 0, 0,   7, 464, 1, 0, 0, 1));
    vecs.push_back(mk(1, 0,   0,   0, 1, 0, 0,   7, 464, 1, 0, 0, 0));

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      resetN = vecs[i].rst_n; spawn = vecs[i].spawn;
      spawnX = vecs[i].sx; spawnY = vecs[i].sy;
      startOfFrame = vecs[i].sof; collisionPaddle = vecs[i].coll;
      pause = vecs[i].pause;
      tick();
      chk_all($sformatf("vec%0d", i), int'(vecs[i].ex), int'(vecs[i].ey),
              vecs[i].epre, vecs[i].eact, vecs[i].ecaught, vecs[i].emissed);
    end
    idle_inputs();

    // Long fall from row 0: speeds 64,72,...,256 then saturated at 256
    spawn = 1'b1; spawnX = 11'd300; spawnY = 11'd0;
    tick();
    spawn = 1'b0;
    chk_all("fall.spawn", 300, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    frames(1, 1'b0);
    chk("fall.f1.y", int'(topLeftMoveY), 1);
    frames(1, 1'b0);
    chk("fall.f2.y", int'(topLeftMoveY), 2);
    frames(10, 1'b1);
    chk("fall.paused.y", int'(topLeftMoveY), 2);
    frames(1, 1'b0);
    chk("fall.f3.y", int'(topLeftMoveY), 3);
    frames(22, 1'b0);
    chk("fall.f25.y", int'(topLeftMoveY), 62);
    frames(1, 1'b0);
    chk("fall.f26.y", int'(topLeftMoveY), 66);
    frames(4, 1'b0);
    chk("fall.f30.y", int'(topLeftMoveY), 82);
    frames(95, 1'b0);
    chk_all("fall.f125", 300, 462, 1'b0, 1'b1, 1'b0, 1'b0);
    frames(1, 1'b0);
    chk_all("fall.exit", 300, 466, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    chk_all("fall.after_exit", 300, 466, 1'b1, 1'b0, 1'b0, 1'b0);

    // Catch mid-fall at row 300 while paused, with a frame pulse alongside
    spawn = 1'b1; spawnX = 11'd20; spawnY = 11'd300;
    tick();
    spawn = 1'b0;
    collisionPaddle = 1'b1; startOfFrame = 1'b1; pause = 1'b1;
    tick();
    idle_inputs();
    chk_all("catch", 20, 300, 1'b1, 1'b0, 1'b1, 1'b0);
    frames(1, 1'b0);
    chk_all("catch.after", 20, 300, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
